// File: rtl/mem_stage.sv
// MEM pipeline stage of the 64-bit core, sitting between EX/MEM and MEM_WB.
// Issues loads/stores on a req/gnt/rvalid data bus, stalls the pipeline while
// an access is outstanding, steers store data into byte lanes and extends
// load data. Pass-through fields follow ex_* combinationally in every state.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_*                     EX/MEM register contents (held stable while stall=1)
//   stall                    hold PC/IF/ID/EX/MEM registers
//   mem_*                    MEM_WB inputs (read data, pass-through, error pulses)
//   dmem_req/we/addr/wdata/be, dmem_gnt/rvalid/rdata   data-memory bus
//
// Optional feature: define MEM_TIMEOUT_EN to enable the WAIT-state timeout that
// ends a hung access with a one-cycle mem_bus_err after TIMEOUT_CYCLES cycles.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [63:0] ex_alu_result,
  input  logic [63:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_to_reg,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  output logic        stall,
  output logic [63:0] mem_read_data,
  output logic [63:0] mem_alu_result,
  output logic [4:0]  mem_rd,
  output logic        mem_reg_write,
  output logic        mem_mem_to_reg,
  output logic        mem_misalign,
  output logic        mem_bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [63:0] dmem_rdata
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q, we_q;
  logic [63:0] rdata_q;
  logic        err_q, err_d;

  logic        mem_op, misalign, expire;
  logic [1:0]  size;
  logic [7:0]  size_mask;
  logic [2:0]  off;
  logic [63:0] shifted, ext;

  assign size   = ex_funct3[1:0];
  assign off    = ex_alu_result[2:0];
  assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);

  always_comb begin
    misalign  = 1'b0;
    size_mask = 8'h00;
    unique case (size)
      2'd0: begin misalign = 1'b0;      size_mask = 8'h01; end
      2'd1: begin misalign = off[0];    size_mask = 8'h03; end
      2'd2: begin misalign = |off[1:0]; size_mask = 8'h0F; end
      2'd3: begin misalign = |off;      size_mask = 8'hFF; end
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Counter is held at zero outside WAIT, so it starts from zero on entry.
  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (state_q == StWait) begin
      if (!dmem_rvalid) begin
        cnt_d  = cnt_q + 8'd1;
        expire = (cnt_d == 8'(TIMEOUT_CYCLES));
      end
    end else begin
      cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    dmem_req = 1'b0;
    stall    = 1'b0;
    unique case (state_q)
      StIdle: begin
        err_d = 1'b0;
        if (mem_op && !misalign) begin
          dmem_req = 1'b1;
          stall    = 1'b1;
          if (dmem_gnt) state_d = StWait;
        end
      end
      StWait: begin
        stall = 1'b1;
        // A response arriving in the expiry cycle still completes normally.
        if (dmem_rvalid) begin
          state_d = StDone;
          err_d   = 1'b0;
        end else if (expire) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      off_q   <= 3'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (state_q == StIdle && dmem_req && dmem_gnt) begin
        off_q  <= off;
        size_q <= size;
        uns_q  <= ex_funct3[2];
        we_q   <= ~ex_mem_read;
      end
      if (state_q == StWait && dmem_rvalid) rdata_q <= dmem_rdata;
    end
  end

  // Load extraction from the captured doubleword.
  assign shifted = rdata_q >> {off_q, 3'b000};

  always_comb begin
    ext = shifted;
    unique case (size_q)
      2'd0: ext = {{56{shifted[7]  & ~uns_q}}, shifted[7:0]};
      2'd1: ext = {{48{shifted[15] & ~uns_q}}, shifted[15:0]};
      2'd2: ext = {{32{shifted[31] & ~uns_q}}, shifted[31:0]};
      2'd3: ext = shifted;
    endcase
  end

  // Bus fields are zeroed when no request is issued.
  assign dmem_we    = dmem_req & ~ex_mem_read;
  assign dmem_addr  = dmem_req ? {ex_alu_result[63:3], 3'b000} : 64'd0;
  assign dmem_be    = dmem_req ? (size_mask << off) : 8'd0;
  assign dmem_wdata = dmem_req ? (ex_store_data << {off, 3'b000}) : 64'd0;

  assign mem_misalign   = (state_q == StIdle) & mem_op & misalign;
  assign mem_bus_err    = (state_q == StDone) & err_q;
  assign mem_read_data  = (state_q == StDone && !we_q && !err_q) ? ext : 64'd0;
  assign mem_reg_write  = ex_reg_write & ex_valid & ~mem_misalign & ~mem_bus_err;
  assign mem_alu_result = ex_alu_result;
  assign mem_rd         = ex_rd;
  assign mem_mem_to_reg = ex_mem_to_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: the bench acts as the data memory,
// pushes expected results per access into a queue and pops them when the
// stage leaves stall.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
  logic [63:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic        stall, mem_reg_write, mem_mem_to_reg, mem_misalign, mem_bus_err;
  logic [63:0] mem_read_data, mem_alu_result;
  logic [4:0]  mem_rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_be;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
    .stall(stall), .mem_read_data(mem_read_data), .mem_alu_result(mem_alu_result),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_misalign(mem_misalign), .mem_bus_err(mem_bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic        we;
    logic [63:0] rdata;
    logic        reg_write;
    logic        bus_err;
    int          stall_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [63:0] addr, input logic [7:0] be, input logic [63:0] wdata,
                      input logic we, input logic [63:0] rdata, input logic rw,
                      input logic err, input int stalls);
    exp_t e;
    e.addr = addr; e.be = be; e.wdata = wdata; e.we = we; e.rdata = rdata;
    e.reg_write = rw; e.bus_err = err; e.stall_cyc = stalls;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_rd = '0;
    ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_funct3 = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
  endtask

  // Runs one access; rv_dly is the WAIT cycle index carrying rvalid (-1 = never).
  task automatic mem_op(input logic [63:0] addr, input logic [63:0] wdata, input logic ld,
                        input logic [2:0] f3, input int gnt_dly, input int rv_dly,
                        input logic [63:0] rdata);
    exp_t        e;
    logic [63:0] o_addr, o_wdata;
    logic [7:0]  o_be;
    logic        o_we;
    int          stall_cyc = 0;
    int          req_cyc = 0;
    bit          done = 0;
    @(negedge clk);
    ex_valid = 1'b1; ex_alu_result = addr; ex_store_data = wdata; ex_rd = 5'd7;
    ex_reg_write = ld; ex_mem_to_reg = ld; ex_mem_read = ld; ex_mem_write = ~ld;
    ex_funct3 = f3;
    for (int i = 0; i <= gnt_dly; i++) begin
      if (i > 0) @(negedge clk);
      dmem_gnt = (i == gnt_dly);
      #1;
      if (stall) stall_cyc++;
      if (dmem_req) req_cyc++;
    end
    o_addr = dmem_addr; o_wdata = dmem_wdata; o_be = dmem_be; o_we = dmem_we;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      dmem_gnt = 1'b0;
      dmem_rvalid = (i == rv_dly);
      dmem_rdata = rdata;
      #1;
      if (stall) stall_cyc++;
      else done = 1;
    end
    dmem_rvalid = 1'b0;
    check("completion_seen", 64'(done), 64'd1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check("req_cycles", 64'(req_cyc), 64'(gnt_dly + 1));
      check("dmem_addr", o_addr, e.addr);
      check("dmem_be", 64'(o_be), 64'(e.be));
      check("dmem_wdata", o_wdata, e.wdata);
      check("dmem_we", 64'(o_we), 64'(e.we));
      check("stall_cycles", 64'(stall_cyc), 64'(e.stall_cyc));
      check("done_no_req", 64'(dmem_req), 64'd0);
      check("mem_read_data", mem_read_data, e.rdata);
      check("mem_reg_write", 64'(mem_reg_write), 64'(e.reg_write));
      check("mem_bus_err", 64'(mem_bus_err), 64'(e.bus_err));
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_req", 64'(dmem_req), 64'd0);
    check("rst_read_data", mem_read_data, 64'd0);
    check("rst_reg_write", 64'(mem_reg_write), 64'd0);
    check("rst_misalign", 64'(mem_misalign), 64'd0);
    check("rst_bus_err", 64'(mem_bus_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Non-memory op: zero-latency pass-through.
    @(negedge clk);
    ex_valid = 1'b1; ex_alu_result = 64'h1234; ex_rd = 5'd5; ex_reg_write = 1'b1;
    #1;
    check("alu_stall", 64'(stall), 64'd0);
    check("alu_result", mem_alu_result, 64'h1234);
    check("alu_rd", 64'(mem_rd), 64'd5);
    check("alu_reg_write", 64'(mem_reg_write), 64'd1);
    check("alu_no_req", 64'(dmem_req), 64'd0);
    check("alu_read_data", mem_read_data, 64'd0);
    @(negedge clk);
    idle_inputs();

    // LB / LBU at byte 3.
    push(64'h1000, 8'h08, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0, 2);
    mem_op(64'h1003, 64'd0, 1'b1, 3'b000, 0, 0, 64'h0000_0000_8000_0000);
    push(64'h1000, 8'h08, 64'd0, 1'b0, 64'h80, 1'b1, 1'b0, 2);
    mem_op(64'h1003, 64'd0, 1'b1, 3'b100, 0, 0, 64'h0000_0000_8000_0000);

    // SH with grant delayed 3 cycles.
    push(64'h2000, 8'hC0, 64'hBEEF_0000_0000_0000, 1'b1, 64'd0, 1'b0, 1'b0, 5);
    mem_op(64'h2006, 64'hBEEF, 1'b0, 3'b001, 3, 0, 64'hFFFF_FFFF_FFFF_FFFF);

    // LD with slow response, LW signed upper word, LHU.
    push(64'h4000, 8'hFF, 64'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 4);
    mem_op(64'h4000, 64'd0, 1'b1, 3'b011, 0, 2, 64'h0123_4567_89AB_CDEF);
    push(64'h3000, 8'hF0, 64'd0, 1'b0, 64'hFFFF_FFFF_8000_0001, 1'b1, 1'b0, 2);
    mem_op(64'h3004, 64'd0, 1'b1, 3'b010, 0, 0, 64'h8000_0001_0000_0000);
    push(64'h5000, 8'h0C, 64'd0, 1'b0, 64'hF00D, 1'b1, 1'b0, 3);
    mem_op(64'h5002, 64'd0, 1'b1, 3'b101, 1, 0, 64'h0000_0000_F00D_0000);

    // Misaligned LW.
    @(negedge clk);
    ex_valid = 1'b1; ex_alu_result = 64'h3002; ex_rd = 5'd9; ex_reg_write = 1'b1;
    ex_mem_read = 1'b1; ex_mem_to_reg = 1'b1; ex_funct3 = 3'b010;
    #1;
    check("mis_pulse", 64'(mem_misalign), 64'd1);
    check("mis_no_req", 64'(dmem_req), 64'd0);
    check("mis_reg_write", 64'(mem_reg_write), 64'd0);
    check("mis_stall", 64'(stall), 64'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("mis_pulse_end", 64'(mem_misalign), 64'd0);

    // Reset while in WAIT, then a stale response.
    @(negedge clk);
    ex_valid = 1'b1; ex_alu_result = 64'h6000; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    ex_funct3 = 3'b011; dmem_gnt = 1'b1;
    #1;
    check("rw_req", 64'(dmem_req), 64'd1);
    @(negedge clk);
    dmem_gnt = 1'b0;
    #1;
    check("rw_wait_stall", 64'(stall), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    dmem_rvalid = 1'b1; dmem_rdata = 64'hDEAD_BEEF;
    #1;
    check("rw_post_stall", 64'(stall), 64'd0);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    check("rw_stale_stall", 64'(stall), 64'd0);
    check("rw_stale_data", mem_read_data, 64'd0);
    push(64'h1000, 8'h08, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0, 2);
    mem_op(64'h1003, 64'd0, 1'b1, 3'b000, 0, 0, 64'h0000_0000_8000_0000);

`ifdef MEM_TIMEOUT_EN
    // No response: 4 WAIT cycles then bus error.
    push(64'h7000, 8'hFF, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 5);
    mem_op(64'h7000, 64'd0, 1'b1, 3'b011, 0, -1, 64'h1111);
    // Response in the expiry cycle wins.
    push(64'h7000, 8'hFF, 64'd0, 1'b0, 64'h2222, 1'b1, 1'b0, 5);
    mem_op(64'h7000, 64'd0, 1'b1, 3'b011, 0, 3, 64'h2222);
`else
    // Without the timeout, WAIT persists until the response.
    push(64'h7000, 8'hFF, 64'd0, 1'b0, 64'h3333, 1'b1, 1'b0, 7);
    mem_op(64'h7000, 64'd0, 1'b1, 3'b011, 0, 5, 64'h3333);
`endif

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
